// File: rtl/filter_stream_io.sv
// filter_stream_io
//   Environment-side partner of the filter's 4-phase req/ack sample interface.
//   Serves input requests from a host-written input FIFO and captures filter
//   results into a host-readable output FIFO.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wr_valid/wr_ready/wr_data  host -> input FIFO (push on valid && ready)
//   rd_valid/rd_ready/rd_data  output FIFO -> host (pop on valid && ready)
//   f_req_in/f_ack_in/f_data_in     filter input-sample handshake
//   f_req_out/f_ack_out/f_data_out  filter result handshake
//   in_count, out_count      FIFO occupancies (0..DEPTH)
//   proto_err                sticky: a req was withdrawn before its ack
module filter_stream_io #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AWIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rd_data,
  input  logic              f_req_in,
  output logic              f_ack_in,
  output logic [DWIDTH-1:0] f_data_in,
  input  logic              f_req_out,
  output logic              f_ack_out,
  input  logic [DWIDTH-1:0] f_data_out,
  output logic [AWIDTH:0]   in_count,
  output logic [AWIDTH:0]   out_count,
  output logic              proto_err
);

  typedef enum logic {S_IDLE, S_ACK} hs_state_e;

  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);

  // Input FIFO
  logic [DWIDTH-1:0] in_mem_q [DEPTH];
  logic [AWIDTH-1:0] in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [AWIDTH:0]   in_cnt_q, in_cnt_d;
  logic              in_push, in_pop, in_full, in_empty;

  // Output FIFO
  logic [DWIDTH-1:0] out_mem_q [DEPTH];
  logic [AWIDTH-1:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [AWIDTH:0]   out_cnt_q, out_cnt_d;
  logic              out_push, out_pop, out_full, out_empty;

  // Handshake FSMs
  hs_state_e         in_state_q, in_state_d, out_state_q, out_state_d;
  logic              f_ack_in_q, f_ack_in_d, f_ack_out_q, f_ack_out_d;
  logic [DWIDTH-1:0] f_data_in_q, f_data_in_d;
  logic              req_in_prev_q, req_out_prev_q;
  logic              proto_err_q, proto_err_d;

  assign in_full   = (in_cnt_q == FULL_CNT);
  assign in_empty  = (in_cnt_q == '0);
  assign out_full  = (out_cnt_q == FULL_CNT);
  assign out_empty = (out_cnt_q == '0);

  assign wr_ready  = !in_full;
  assign rd_valid  = !out_empty;
  assign rd_data   = out_mem_q[out_rptr_q];
  assign f_ack_in  = f_ack_in_q;
  assign f_data_in = f_data_in_q;
  assign f_ack_out = f_ack_out_q;
  assign in_count  = in_cnt_q;
  assign out_count = out_cnt_q;
  assign proto_err = proto_err_q;

  assign in_push = wr_valid && !in_full;
  assign out_pop = rd_ready && !out_empty;

  // Input FSM: FIFO head is read from registered state only, so a sample
  // pushed this cycle cannot reach the filter until the next one.
  always_comb begin
    in_state_d  = in_state_q;
    f_ack_in_d  = f_ack_in_q;
    f_data_in_d = f_data_in_q;
    in_pop      = 1'b0;
    unique case (in_state_q)
      S_IDLE: begin
        if (f_req_in && !in_empty) begin
          f_data_in_d = in_mem_q[in_rptr_q];
          in_pop      = 1'b1;
          f_ack_in_d  = 1'b1;
          in_state_d  = S_ACK;
        end
      end
      S_ACK: begin
        if (!f_req_in) begin
          f_ack_in_d = 1'b0;
          in_state_d = S_IDLE;
        end
      end
      default: in_state_d = S_IDLE;
    endcase
  end

  // Output FSM: a full FIFO withholds the ack; a host pop in the same cycle
  // frees the slot only for the following cycle.
  always_comb begin
    out_state_d = out_state_q;
    f_ack_out_d = f_ack_out_q;
    out_push    = 1'b0;
    unique case (out_state_q)
      S_IDLE: begin
        if (f_req_out && !out_full) begin
          out_push    = 1'b1;
          f_ack_out_d = 1'b1;
          out_state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (!f_req_out) begin
          f_ack_out_d = 1'b0;
          out_state_d = S_IDLE;
        end
      end
      default: out_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_wptr_d  = in_push  ? in_wptr_q  + AWIDTH'(1) : in_wptr_q;
    in_rptr_d  = in_pop   ? in_rptr_q  + AWIDTH'(1) : in_rptr_q;
    out_wptr_d = out_push ? out_wptr_q + AWIDTH'(1) : out_wptr_q;
    out_rptr_d = out_pop  ? out_rptr_q + AWIDTH'(1) : out_rptr_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    if (in_push && !in_pop)   in_cnt_d  = in_cnt_q + 1'b1;
    if (!in_push && in_pop)   in_cnt_d  = in_cnt_q - 1'b1;
    if (out_push && !out_pop) out_cnt_d = out_cnt_q + 1'b1;
    if (!out_push && out_pop) out_cnt_d = out_cnt_q - 1'b1;
  end

  // A falling req seen while still IDLE means it was withdrawn before ack.
  always_comb begin
    proto_err_d = proto_err_q;
    if (in_state_q == S_IDLE && req_in_prev_q && !f_req_in)
      proto_err_d = 1'b1;
    if (out_state_q == S_IDLE && req_out_prev_q && !f_req_out)
      proto_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_wptr_q      <= '0;
      in_rptr_q      <= '0;
      in_cnt_q       <= '0;
      out_wptr_q     <= '0;
      out_rptr_q     <= '0;
      out_cnt_q      <= '0;
      in_state_q     <= S_IDLE;
      out_state_q    <= S_IDLE;
      f_ack_in_q     <= 1'b0;
      f_ack_out_q    <= 1'b0;
      f_data_in_q    <= '0;
      req_in_prev_q  <= 1'b0;
      req_out_prev_q <= 1'b0;
      proto_err_q    <= 1'b0;
    end else begin
      in_wptr_q      <= in_wptr_d;
      in_rptr_q      <= in_rptr_d;
      in_cnt_q       <= in_cnt_d;
      out_wptr_q     <= out_wptr_d;
      out_rptr_q     <= out_rptr_d;
      out_cnt_q      <= out_cnt_d;
      in_state_q     <= in_state_d;
      out_state_q    <= out_state_d;
      f_ack_in_q     <= f_ack_in_d;
      f_ack_out_q    <= f_ack_out_d;
      f_data_in_q    <= f_data_in_d;
      req_in_prev_q  <= f_req_in;
      req_out_prev_q <= f_req_out;
      proto_err_q    <= proto_err_d;
    end
  end

  // Storage is not reset; pointer/count reset is what discards contents.
  always_ff @(posedge clk) begin
    if (in_push && !rst)  in_mem_q[in_wptr_q]   <= wr_data;
    if (out_push && !rst) out_mem_q[out_wptr_q] <= f_data_out;
  end

endmodule

// File: tb/tb_filter_stream_io.sv
module tb_filter_stream_io;

  localparam int unsigned DW = 16;
  localparam int unsigned DP = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          f_req_in = 1'b0;
  logic          f_ack_in;
  logic [DW-1:0] f_data_in;
  logic          f_req_out = 1'b0;
  logic          f_ack_out;
  logic [DW-1:0] f_data_out = '0;
  logic [AW:0]   in_count;
  logic [AW:0]   out_count;
  logic          proto_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_fin[$];
  logic [DW-1:0] exp_rd[$];
  logic          ack_in_prev = 1'b0;

  filter_stream_io #(.DWIDTH(DW), .DEPTH(DP), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .f_req_in(f_req_in), .f_ack_in(f_ack_in), .f_data_in(f_data_in),
    .f_req_out(f_req_out), .f_ack_out(f_ack_out), .f_data_out(f_data_out),
    .in_count(in_count), .out_count(out_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares each sample delivered to the filter and
  // each result taken by the host against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (f_ack_in && !ack_in_prev) begin
        if (exp_fin.size() == 0) begin
          checks++; errors++;
          $display("FAIL f_data_in_unexpected: got 0x%0h expected none", f_data_in);
        end else begin
          check("f_data_in", 32'(f_data_in), 32'(exp_fin.pop_front()));
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_data_unexpected: got 0x%0h expected none", rd_data);
        end else begin
          check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
        end
      end
    end
    ack_in_prev = f_ack_in;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [DW-1:0] d);
    check("wr_ready_before_write", 32'(wr_ready), 1);
    wr_data  = d;
    wr_valid = 1'b1;
    exp_fin.push_back(d);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic hs_in();
    int n = 0;
    f_req_in = 1'b1;
    do begin tick(); n++; end while (!f_ack_in && n < 4);
    check("hs_in_ack", 32'(f_ack_in), 1);
    f_req_in = 1'b0;
    tick();
    check("hs_in_release", 32'(f_ack_in), 0);
  endtask

  task automatic hs_out(input logic [DW-1:0] d);
    int n = 0;
    f_data_out = d;
    f_req_out  = 1'b1;
    exp_rd.push_back(d);
    do begin tick(); n++; end while (!f_ack_out && n < 4);
    check("hs_out_ack", 32'(f_ack_out), 1);
    f_req_out = 1'b0;
    tick();
    check("hs_out_release", 32'(f_ack_out), 0);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ack_in", 32'(f_ack_in), 0);
    check("rst_ack_out", 32'(f_ack_out), 0);
    check("rst_data_in", 32'(f_data_in), 0);
    check("rst_in_count", 32'(in_count), 0);
    check("rst_out_count", 32'(out_count), 0);
    check("rst_proto_err", 32'(proto_err), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_rd_valid", 32'(rd_valid), 0);
    rst = 1'b0;
    tick();

    // Basic input handshake
    host_write(16'h0003);
    host_write(16'h0005);
    check("in_count_2", 32'(in_count), 2);
    f_req_in = 1'b1;
    tick();
    check("t1_ack_in", 32'(f_ack_in), 1);
    check("t1_in_count", 32'(in_count), 1);
    f_req_in = 1'b0;
    tick();
    check("t1_ack_drop", 32'(f_ack_in), 0);
    hs_in();
    check("in_count_0", 32'(in_count), 0);

    // Starved filter, then late sample
    f_req_in = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (f_ack_in) seen++; end
      check("starve_no_ack", 32'(seen), 0);
    end
    host_write(16'h7FFF);
    check("no_bypass", 32'(f_ack_in), 0);
    tick();
    check("late_ack", 32'(f_ack_in), 1);
    f_req_in = 1'b0;
    tick();
    check("late_ack_drop", 32'(f_ack_in), 0);

    // Output capture, held req pushes once
    f_data_out = 16'hFFF1;
    f_req_out  = 1'b1;
    exp_rd.push_back(16'hFFF1);
    tick();
    check("out_ack", 32'(f_ack_out), 1);
    check("out_rd_valid", 32'(rd_valid), 1);
    check("out_rd_data", 32'(rd_data), 32'hFFF1);
    check("out_count_1", 32'(out_count), 1);
    for (int i = 0; i < 5; i++) tick();
    check("out_count_hold", 32'(out_count), 1);
    f_req_out = 1'b0;
    tick();
    check("out_ack_drop", 32'(f_ack_out), 0);

    // Fill output FIFO, then stall on full
    for (int i = 0; i < 7; i++) hs_out(16'h0100 + 16'(i));
    check("out_count_full", 32'(out_count), 8);
    f_data_out = 16'hABCD;
    f_req_out  = 1'b1;
    tick(); tick(); tick();
    check("full_no_ack", 32'(f_ack_out), 0);
    exp_rd.push_back(16'hABCD);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("pop_full_count", 32'(out_count), 7);
    check("pop_full_no_ack_yet", 32'(f_ack_out), 0);
    tick();
    check("refill_ack", 32'(f_ack_out), 1);
    check("refill_count", 32'(out_count), 8);
    f_req_out = 1'b0;
    tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    rd_ready = 1'b0;
    check("drain_out_count", 32'(out_count), 0);

    // Input pointer wrap: DEPTH+3 writes across 3 handshakes
    for (int i = 0; i < 8; i++) host_write(16'hA000 + 16'(i));
    check("wrap_full_count", 32'(in_count), 8);
    check("wrap_full_wr_ready", 32'(wr_ready), 0);
    for (int k = 0; k < 3; k++) begin
      hs_in();
      check("wrap_free_wr_ready", 32'(wr_ready), 1);
      host_write(16'hB000 + 16'(k));
      check("wrap_refull_wr_ready", 32'(wr_ready), 0);
    end
    for (int i = 0; i < 8; i++) hs_in();
    check("wrap_empty", 32'(in_count), 0);

    // Protocol error: req withdrawn before ack
    f_req_in = 1'b1;
    tick();
    check("proto_before", 32'(proto_err), 0);
    f_req_in = 1'b0;
    tick();
    check("proto_set", 32'(proto_err), 1);
    tick(); tick(); tick();
    check("proto_sticky", 32'(proto_err), 1);

    // Reset mid-handshake
    host_write(16'h1234);
    host_write(16'h2222);
    f_data_out = 16'h5555;
    f_req_in   = 1'b1;
    f_req_out  = 1'b1;
    tick();
    check("mid_ack_in", 32'(f_ack_in), 1);
    check("mid_ack_out", 32'(f_ack_out), 1);
    rst = 1'b1;
    f_req_in  = 1'b0;
    f_req_out = 1'b0;
    tick();
    check("mid_rst_ack_in", 32'(f_ack_in), 0);
    check("mid_rst_ack_out", 32'(f_ack_out), 0);
    check("mid_rst_in_count", 32'(in_count), 0);
    check("mid_rst_out_count", 32'(out_count), 0);
    check("mid_rst_proto", 32'(proto_err), 0);
    exp_fin.delete();
    exp_rd.delete();
    rst = 1'b0;
    tick(); tick();
    check("post_rst_proto", 32'(proto_err), 0);
    check("post_rst_rd_valid", 32'(rd_valid), 0);

    check("sb_fin_empty", 32'(exp_fin.size()), 0);
    check("sb_rd_empty", 32'(exp_rd.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/filter_stream_io.md
Name: filter_stream_io

Overview:
- Environment-side counterpart of the filter's 4-phase req/ack sample interface.
- Responds to the filter's input requests (f_req_in) by supplying samples from a host-written input FIFO.
- Responds to the filter's output requests (f_req_out) by capturing results into a host-readable output FIFO.
- Sits between the filter core and the host/testbench stream ports, so the filter runs from buffered data without cycle-exact host involvement.

Parameters:
- DWIDTH, 16, sample width on both filter-side and host-side data paths.
- DEPTH, 8, entries per FIFO (input and output); power of two, minimum 2.
- AWIDTH, 3, log2(DEPTH); pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  host offers input sample.
- wr_ready  out  1  input FIFO not full.
- wr_data  in  DWIDTH  host input sample.
- rd_valid  out  1  output FIFO not empty.
- rd_ready  in  1  host accepts result.
- rd_data  out  DWIDTH  head of output FIFO.
- f_req_in  in  1  filter requests an input sample.
- f_ack_in  out  1  sample valid on f_data_in.
- f_data_in  out  DWIDTH  sample to filter.
- f_req_out  in  1  filter has a result on f_data_out.
- f_ack_out  out  1  result captured.
- f_data_out  in  DWIDTH  result from filter.
- in_count  out  AWIDTH+1  input FIFO occupancy.
- out_count  out  AWIDTH+1  output FIFO occupancy.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at posedge):
  - f_ack_in=0, f_ack_out=0, f_data_in=0.
  - Both FIFOs empty; counts=0.
  - proto_err=0; both FSMs go to IDLE.
  - Reset mid-handshake drops ack the next edge and discards all buffered data.
- Host input FIFO:
  - wr_ready = !full; push when wr_valid && wr_ready.
  - No bypass: a sample is never visible to the filter in its push cycle.
- Host output FIFO:
  - rd_valid = !empty; rd_data = head; pop when rd_valid && rd_ready.
  - A push and pop in the same cycle leave the count unchanged.
  - A pop while full is allowed; the freed slot is usable next cycle.
- Pointers wrap modulo DEPTH; counts range 0..DEPTH.
- Input FSM, states IDLE and ACK:
  - IDLE: if f_req_in=1 && in FIFO not empty: register f_data_in <= head, pop, f_ack_in <= 1, go to ACK. Ack is visible 1 cycle after req is sampled.
  - IDLE with empty FIFO: hold f_ack_in=0 and wait; the filter stalls.
  - ACK: hold f_ack_in=1 and f_data_in stable until f_req_in=0 is sampled, then f_ack_in <= 0, go to IDLE.
  - Ack remains high for exactly 1 cycle after req falls (4-phase return-to-zero).
  - f_data_in keeps its last value in IDLE.
- Output FSM, states IDLE and ACK:
  - IDLE: if f_req_out=1 && out FIFO not full: push f_data_out (sampled that edge), f_ack_out <= 1, go to ACK.
  - IDLE with full FIFO: no ack; the filter stalls with req held.
  - ACK: hold f_ack_out=1 until f_req_out=0 is sampled, then f_ack_out <= 0, go to IDLE.
- The two FSMs are independent. Simultaneous f_req_in/f_req_out, which the filter issues together, are served in the same cycle when resources allow.
- A FIFO pop/push by an FSM and a host access on the same FIFO in the same cycle are both honoured.
- proto_err is set (sticky until rst) when:
  - f_req_in falls while the input FSM is IDLE, or
  - f_req_out falls while the output FSM is IDLE (req withdrawn before ack).
  - Operation continues unchanged after the flag is set.
- No arithmetic on data; samples pass bit-exact.

Test Plan:
- Reset then write 0x0003, 0x0005: in_count=2. Filter raises f_req_in → f_ack_in=1 next cycle with f_data_in=0x0003, in_count=1. Drop req → ack=0 one cycle later.
- Empty input FIFO with f_req_in=1 for 10 cycles → f_ack_in stays 0. Write 0x7FFF → ack within 2 cycles of the push, data 0x7FFF.
- f_req_out=1 with f_data_out=0xFFF1 → f_ack_out=1 next cycle, rd_valid=1, rd_data=0xFFF1, out_count=1. Hold req 5 cycles → only one push occurs.
- Fill output FIFO with 8 results, then assert f_req_out → no ack. Host pops one → ack follows, out_count returns to 8.
- Write DEPTH+3 samples across 3 filter handshakes (pointer wrap) → filter receives the samples in write order, wr_ready=0 only while in_count=8.
- Raise and drop f_req_in while FIFO empty → proto_err=1 and stays 1. Assert rst mid-ACK → acks=0, counts=0, proto_err=0 next cycle.
